punc_control_mc: RTL

Multi-cycle control unit for the PUnC LC3 processor. It supports variable-latency memory, either through fixed wait states or a ready handshake. It sequences fetch, decode and execute (including two-phase LDI/STI), resolves branches internally from datapath condition codes, and exposes halt, illegal-opcode and retired-instruction status. It sits between the instruction register and the existing PUnC datapath and drives all of the datapath's control strobes.

---
 rtl/punc_pkg.sv | 70 +++++++
 rtl/punc_mem_phase.sv | 34 +++
 rtl/punc_control_mc.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/punc_pkg.sv
// punc_pkg: opcodes, IR field ranges, state type and datapath
// select encodings shared by the PUnC multi-cycle control unit.

`define IR_OPC 15:12
`define IR_DR  11:9
`define IR_NZP 11:9
`define IR_SR1 8:6
`define IR_SR2 2:0
`define IR_IMM 5
`define IR_JSR 11

package punc_pkg;

    localparam logic [3:0] OC_BR  = 4'b0000;
    localparam logic [3:0] OC_ADD = 4'b0001;
    localparam logic [3:0] OC_LD  = 4'b0010;
    localparam logic [3:0] OC_ST  = 4'b0011;
    localparam logic [3:0] OC_JSR = 4'b0100;
    localparam logic [3:0] OC_AND = 4'b0101;
    localparam logic [3:0] OC_LDR = 4'b0110;
    localparam logic [3:0] OC_STR = 4'b0111;
    localparam logic [3:0] OC_RTI = 4'b1000;
    localparam logic [3:0] OC_NOT = 4'b1001;
    localparam logic [3:0] OC_LDI = 4'b1010;
    localparam logic [3:0] OC_STI = 4'b1011;
    localparam logic [3:0] OC_JMP = 4'b1100;
    localparam logic [3:0] OC_RES = 4'b1101;
    localparam logic [3:0] OC_LEA = 4'b1110;
    localparam logic [3:0] OC_HLT = 4'b1111;

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_EXEC2,
        S_HALT
    } state_t;

    localparam logic [1:0] ADDR_PC     = 2'd0;
    localparam logic [1:0] ADDR_PC_OFF = 2'd1;
    localparam logic [1:0] ADDR_IND    = 2'd2;
    localparam logic [1:0] ADDR_BASE   = 2'd3;

    localparam logic [1:0] WD_ALU    = 2'd0;
    localparam logic [1:0] WD_PC     = 2'd1;
    localparam logic [1:0] WD_MEM    = 2'd2;
    localparam logic [1:0] WD_PC_OFF = 2'd3;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_AND  = 2'd2;
    localparam logic [1:0] ALU_NOT  = 2'd3;

    localparam logic [1:0] SX_IMM5  = 2'd0;
    localparam logic [1:0] SX_OFF6  = 2'd1;
    localparam logic [1:0] SX_OFF9  = 2'd2;
    localparam logic [1:0] SX_OFF11 = 2'd3;

    function automatic logic is_illegal(input logic [3:0] opc);
        return (opc == OC_RTI) || (opc == OC_RES);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] opc);
        return (opc == OC_LD)  || (opc == OC_LDR) ||
               (opc == OC_ST)  || (opc == OC_STR) ||
               (opc == OC_LDI) || (opc == OC_STI);
    endfunction

endpackage

// File: rtl/punc_mem_phase.sv
// punc_mem_phase: decides when the current memory phase completes,
// either after MEM_WAIT+1 cycles or on the first mem_rdy while active.

module punc_mem_phase #(
    parameter int MEM_WAIT = 0,
    parameter int USE_RDY  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_rdy,
    output logic done
);

    generate
        if (USE_RDY != 0) begin : g_rdy
            logic unused_rdy;
            assign unused_rdy = ^{clk, rst};
            assign done = active & mem_rdy;
        end else begin : g_wait
            localparam logic [3:0] LAST = 4'(MEM_WAIT);
            logic [3:0] cnt;
            logic       unused_wait;
            assign unused_wait = mem_rdy;
            assign done = active && (cnt == LAST);
            // Count cycles spent in the phase; restart at every phase boundary.
            always_ff @(posedge clk) begin
                if (rst || !active || done) cnt <= '0;
                else cnt <= cnt + 4'd1;
            end
        end
    endgenerate

endmodule

// File: rtl/punc_control_mc.sv
// punc_control_mc: multi-cycle LC3 control unit sequencing fetch,
// decode and execute against variable-latency memory.

module punc_control_mc
    import punc_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int USE_RDY  = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ir,
    input  logic [2:0]       cc_nzp,
    input  logic             mem_rdy,
    output logic             mem_req,
    output logic             mem_wr_en,
    output logic [1:0]       mem_addr_sel,
    output logic             mdr_ld,
    output logic             ir_ld,
    output logic             pc_ld,
    output logic             pc_up,
    output logic             pc_clr,
    output logic             pc_sel,
    output logic             rf_wr_en,
    output logic [2:0]       rf_wr_addr,
    output logic [2:0]       rf_r_addr_0,
    output logic [2:0]       rf_r_addr_1,
    output logic [1:0]       rf_w_data_sel,
    output logic [1:0]       alu_sel,
    output logic             add_const,
    output logic [1:0]       sext_sel,
    output logic             cc_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] ret_q;
    logic             ill_q;
    logic             ret_inc, ill_set, exec_fin;
    logic             phase_done;
    logic [3:0]       opc;
    logic             unused_ir;

    assign opc       = ir[`IR_OPC];
    assign unused_ir = ^ir[4:3];

    assign halted  = ~rst & (state == S_HALT);
    assign illegal = ~rst & ill_q;
    assign retired = rst ? '0 : ret_q;

    punc_mem_phase #(
        .MEM_WAIT(MEM_WAIT),
        .USE_RDY (USE_RDY)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .active (mem_req),
        .mem_rdy(mem_rdy),
        .done   (phase_done)
    );

    // Memory phase is active in FETCH, EXEC2 and memory-type EXEC.
    always_comb begin
        mem_req = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH, S_EXEC2: mem_req = 1'b1;
                S_EXEC:           mem_req = is_mem_op(opc);
                default:          mem_req = 1'b0;
            endcase
        end
    end

    // Next state and all control strobes; everything is zero under reset.
    always_comb begin
        state_nx      = state;
        ret_inc       = 1'b0;
        ill_set       = 1'b0;
        exec_fin      = 1'b0;
        mem_wr_en     = 1'b0;
        mem_addr_sel  = ADDR_PC;
        mdr_ld        = 1'b0;
        ir_ld         = 1'b0;
        pc_ld         = 1'b0;
        pc_up         = 1'b0;
        pc_clr        = 1'b0;
        pc_sel        = 1'b0;
        rf_wr_en      = 1'b0;
        rf_wr_addr    = 3'd0;
        rf_r_addr_0   = 3'd0;
        rf_r_addr_1   = 3'd0;
        rf_w_data_sel = WD_ALU;
        alu_sel       = ALU_PASS;
        add_const     = 1'b0;
        sext_sel      = SX_IMM5;
        cc_en         = 1'b0;
        if (!rst) begin
            case (state)
                S_INIT: begin
                    pc_clr   = 1'b1;
                    state_nx = S_FETCH;
                end
                S_FETCH: begin
                    mem_addr_sel = ADDR_PC;
                    if (phase_done) begin
                        ir_ld    = 1'b1;
                        state_nx = S_DECODE;
                    end
                end
                S_DECODE: begin
                    pc_up   = 1'b1;
                    ill_set = is_illegal(opc);
                    unique case (1'b1)
                        opc == OC_HLT:   state_nx = S_HALT;
                        is_illegal(opc): state_nx = S_HALT;
                        default:         state_nx = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    rf_wr_addr  = ir[`IR_DR];
                    rf_r_addr_0 = ir[`IR_SR1];
                    rf_r_addr_1 = ir[`IR_SR2];
                    exec_fin    = 1'b1;
                    case (opc)
                        OC_ADD, OC_AND: begin
                            alu_sel   = (opc == OC_ADD) ? ALU_ADD : ALU_AND;
                            add_const = ir[`IR_IMM];
                            sext_sel  = SX_IMM5;
                            rf_wr_en  = 1'b1;
                            cc_en     = 1'b1;
                        end
                        OC_NOT: begin
                            alu_sel  = ALU_NOT;
                            rf_wr_en = 1'b1;
                            cc_en    = 1'b1;
                        end
                        OC_LEA: begin
                            sext_sel      = SX_OFF9;
                            rf_w_data_sel = WD_PC_OFF;
                            rf_wr_en      = 1'b1;
                            cc_en         = 1'b1;
                        end
                        OC_JMP: begin
                            pc_ld  = 1'b1;
                            pc_sel = 1'b1;
                        end
                        OC_JSR: begin
                            rf_wr_addr    = 3'd7;
                            rf_w_data_sel = WD_PC;
                            rf_wr_en      = 1'b1;
                            sext_sel      = SX_OFF11;
                            pc_ld         = 1'b1;
                            pc_sel        = ~ir[`IR_JSR];
                        end
                        OC_BR: begin
                            sext_sel = SX_OFF9;
                            pc_ld    = |(ir[`IR_NZP] & cc_nzp);
                        end
                        OC_LD, OC_LDR: begin
                            mem_addr_sel  = (opc == OC_LD) ? ADDR_PC_OFF : ADDR_BASE;
                            sext_sel      = (opc == OC_LD) ? SX_OFF9 : SX_OFF6;
                            rf_w_data_sel = WD_MEM;
                            rf_wr_en      = phase_done;
                            cc_en         = phase_done;
                            exec_fin      = phase_done;
                        end
                        OC_ST, OC_STR: begin
                            mem_addr_sel = (opc == OC_ST) ? ADDR_PC_OFF : ADDR_BASE;
                            sext_sel     = (opc == OC_ST) ? SX_OFF9 : SX_OFF6;
                            mem_wr_en    = 1'b1;
                            rf_r_addr_1  = ir[`IR_DR];
                            exec_fin     = phase_done;
                        end
                        OC_LDI, OC_STI: begin
                            mem_addr_sel = ADDR_PC_OFF;
                            sext_sel     = SX_OFF9;
                            mdr_ld       = phase_done;
                            exec_fin     = 1'b0;
                            if (phase_done) state_nx = S_EXEC2;
                        end
                        default: exec_fin = 1'b1;
                    endcase
                    if (exec_fin) begin
                        state_nx = S_FETCH;
                        ret_inc  = 1'b1;
                    end
                end
                S_EXEC2: begin
                    mem_addr_sel = ADDR_IND;
                    rf_wr_addr   = ir[`IR_DR];
                    rf_r_addr_1  = ir[`IR_DR];
                    if (opc == OC_STI) begin
                        mem_wr_en = 1'b1;
                    end else begin
                        rf_w_data_sel = WD_MEM;
                        rf_wr_en      = phase_done;
                        cc_en         = phase_done;
                    end
                    if (phase_done) begin
                        state_nx = S_FETCH;
                        ret_inc  = 1'b1;
                    end
                end
                S_HALT:  state_nx = S_HALT;
                default: state_nx = S_INIT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT;
        else state <= state_nx;
    end

    // Retired-instruction counter and sticky illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_q <= '0;
            ill_q <= 1'b0;
        end else begin
            if (ret_inc) ret_q <= ret_q + CNT_W'(1);
            if (ill_set) ill_q <= 1'b1;
        end
    end

endmodule
